// File: rtl/mux_scan_ctrl.sv
// Scan controller for an 8:1 mux. It steps the select through channels 0..7, samples y after
// SETTLE extra cycles per channel, and presents the samples as one word. Define MUX_SCAN_PARITY_EN for a parity output.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic [2:0] s,
  output logic       busy,
  output logic       done,
`ifdef MUX_SCAN_PARITY_EN
  output logic       parity,
`endif
  output logic [7:0] data
);

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SAMPLE, ST_DONE} state_t;

  state_t     state_reg, state_next;
  logic [2:0] s_reg, s_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [7:0] shreg_reg, shreg_next;
  logic [7:0] data_reg, data_next;
  logic       sample_en;
  logic       capture_en;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity_reg;
`endif

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    cnt_next   = cnt_reg;
    sample_en  = 1'b0;
    capture_en = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          s_next     = 3'd0;
          cnt_next   = SETTLE_CNT;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_reg != 4'd0) cnt_next = cnt_reg - 4'd1;
        else                 state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        sample_en = 1'b1;
        if (s_reg == 3'd7) begin
          capture_en = 1'b1;
          state_next = ST_DONE;
        end else begin
          s_next     = s_reg + 3'd1;
          cnt_next   = SETTLE_CNT;
          state_next = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (start) begin
          s_next     = 3'd0;
          cnt_next   = SETTLE_CNT;
          state_next = ST_WAIT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Each shift-register bit only listens to y while the select points at it.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shreg
      assign shreg_next[gi] = (sample_en && s_reg == 3'(gi)) ? y : shreg_reg[gi];
    end
  endgenerate

  // Capturing from shreg_next folds the channel-7 sample into the word on the same edge.
  assign data_next = capture_en ? shreg_next : data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      s_reg      <= 3'd0;
      cnt_reg    <= 4'd0;
      shreg_reg  <= 8'h00;
      data_reg   <= 8'h00;
`ifdef MUX_SCAN_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      s_reg      <= s_next;
      cnt_reg    <= cnt_next;
      shreg_reg  <= shreg_next;
      data_reg   <= data_next;
`ifdef MUX_SCAN_PARITY_EN
      if (capture_en) parity_reg <= ^shreg_next;
`endif
    end
  end

  assign s    = s_reg;
  assign busy = (state_reg == ST_WAIT) || (state_reg == ST_SAMPLE);
  assign done = (state_reg == ST_DONE);
  assign data = data_reg;
`ifdef MUX_SCAN_PARITY_EN
  assign parity = parity_reg;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (SETTLE 0, 1, 3), each feeding a modelled 8:1 mux,
// checked every cycle against a schedule-based reference model plus directed literal checks.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [3];
  logic       start_v [3];
  logic [7:0] inp_v   [3];
  logic       y_v     [3];
  logic [2:0] s_v     [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [7:0] data_v  [3];
`ifdef MUX_SCAN_PARITY_EN
  logic       par_v   [3];
`endif

  int checks = 0;
  int fails  = 0;

  function automatic int settle_of(int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  function automatic int per(int i);
    return settle_of(i) + 2;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      localparam int ST = (gi == 0) ? 0 : (gi == 1) ? 1 : 3;
      assign y_v[gi] = inp_v[gi][s_v[gi]];
      mux_scan_ctrl #(.SETTLE(ST)) dut (
        .clk    (clk),
        .rst    (rst_v[gi]),
        .start  (start_v[gi]),
        .y      (y_v[gi]),
        .s      (s_v[gi]),
        .busy   (busy_v[gi]),
        .done   (done_v[gi]),
`ifdef MUX_SCAN_PARITY_EN
        .parity (par_v[gi]),
`endif
        .data   (data_v[gi])
      );
    end
  endgenerate

  // Reference model: a scan is a numbered sequence of cycles 1..8*P+1 after acceptance;
  // channel k is sampled at the edge that ends cycle (k+1)*P, the word appears in cycle 8*P+1.
  logic       act    [3];
  int         n      [3];
  logic [7:0] sh     [3];
  logic [7:0] md     [3];
  logic [2:0] last_s [3];

  function automatic logic [2:0] chan(int i, int nn);
    return 3'((nn / per(i)) - 1);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_v[i]) begin
        act[i]    <= 1'b0;
        n[i]      <= 0;
        md[i]     <= 8'h00;
        last_s[i] <= 3'd0;
      end else begin
        if (act[i] && (n[i] % per(i) == 0) && n[i] <= 8 * per(i)) begin
          sh[i][chan(i, n[i])] <= inp_v[i][chan(i, n[i])];
          if (n[i] == 8 * per(i)) md[i] <= {inp_v[i][7], sh[i][6:0]};
        end
        if (act[i] && n[i] == 8 * per(i) + 1) begin
          last_s[i] <= 3'd7;
          if (start_v[i]) n[i] <= 1;
          else            act[i] <= 1'b0;
        end else if (act[i]) begin
          n[i] <= n[i] + 1;
        end else if (start_v[i]) begin
          act[i] <= 1'b1;
          n[i]   <= 1;
        end
      end
    end
  end

  function automatic int exp_s(int i);
    if (!act[i]) return int'(last_s[i]);
    if (n[i] >= 8 * per(i) + 1) return 7;
    return (n[i] - 1) / per(i);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, idx, $time, act_v, exp_v);
    end
  endtask

  // Advance one clock and compare every instance against the model away from the edge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("s",    i, 32'(s_v[i]),    32'(exp_s(i)));
      chk("busy", i, 32'(busy_v[i]), 32'(act[i] && n[i] < 8 * per(i) + 1));
      chk("done", i, 32'(done_v[i]), 32'(act[i] && n[i] == 8 * per(i) + 1));
      chk("data", i, 32'(data_v[i]), 32'(md[i]));
`ifdef MUX_SCAN_PARITY_EN
      chk("parity", i, 32'(par_v[i]), 32'(^md[i]));
`endif
    end
  endtask

  task automatic scan(input int idx, input logic [7:0] pat, input int exp_cyc,
                      input logic [7:0] exp_data, input int mod_cyc, input int mod_bit);
    int c;
    inp_v[idx]   = pat;
    start_v[idx] = 1'b1;
    tick();
    start_v[idx] = 1'b0;
    c = 1;
    while (done_v[idx] !== 1'b1 && c < 400) begin
      if (c == mod_cyc) begin
        chk("s_before_sample", idx, 32'(s_v[idx]), 32'(mod_bit));
        inp_v[idx][mod_bit] = 1'b0;
      end
      tick();
      c++;
    end
    chk("done_cycle", idx, 32'(c), 32'(exp_cyc));
    chk("scan_data", idx, 32'(data_v[idx]), 32'(exp_data));
`ifdef MUX_SCAN_PARITY_EN
    chk("scan_parity", idx, 32'(par_v[idx]), 32'(^exp_data));
`endif
    $display("scan inst%0d settle=%0d pat=%02h data=%02h done_cycle=%0d",
             idx, settle_of(idx), pat, data_v[idx], c);
    tick();
    chk("done_width", idx, 32'(done_v[idx]), 32'd0);
  endtask

  initial begin
    int c, d1, d2, ndone, brk;
    for (int i = 0; i < 3; i++) begin
      rst_v[i]   = 1'b1;
      start_v[i] = 1'b0;
      inp_v[i]   = 8'h00;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("reset_s", i, 32'(s_v[i]), 32'd0);
      chk("reset_busy", i, 32'(busy_v[i]), 32'd0);
      chk("reset_data", i, 32'(data_v[i]), 32'd0);
    end

    // Basic capture and settle-time capture with a late input change.
    scan(0, 8'hA6, 17, 8'hA6, 0, 0);
    scan(2, 8'h5C, 41, 8'h54, 17, 3);

    // Start pulses while busy are ignored.
    inp_v[1]   = 8'h3D;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    ndone = 0; d1 = 0; brk = 0;
    for (c = 1; c <= 30; c++) begin
      if (done_v[1] === 1'b1) begin
        ndone++;
        d1 = c;
      end
      if (c <= 24 && busy_v[1] !== 1'b1) brk++;
      start_v[1] = (c == 5 || c == 12);
      tick();
    end
    start_v[1] = 1'b0;
    chk("busy_start_done_count", 1, 32'(ndone), 32'd1);
    chk("busy_start_done_cycle", 1, 32'(d1), 32'd25);
    chk("busy_continuous", 1, 32'(brk), 32'd0);
    chk("busy_start_data", 1, 32'(data_v[1]), 32'h3D);
    $display("scan inst1 settle=1 pat=3d data=%02h done_cycle=%0d (restarts ignored)", data_v[1], d1);

    // Back-to-back scans with start held high.
    inp_v[0]   = 8'hFF;
    start_v[0] = 1'b1;
    tick();
    d1 = 0; d2 = 0;
    for (c = 1; c <= 40; c++) begin
      if (done_v[0] === 1'b1) begin
        if (d1 == 0) begin
          d1 = c;
          chk("b2b_data1", 0, 32'(data_v[0]), 32'hFF);
`ifdef MUX_SCAN_PARITY_EN
          chk("b2b_parity1", 0, 32'(par_v[0]), 32'd0);
`endif
          inp_v[0] = 8'h07;
        end else if (d2 == 0) begin
          d2 = c;
          chk("b2b_data2", 0, 32'(data_v[0]), 32'h07);
`ifdef MUX_SCAN_PARITY_EN
          chk("b2b_parity2", 0, 32'(par_v[0]), 32'd1);
`endif
          start_v[0] = 1'b0;
        end
      end
      tick();
    end
    start_v[0] = 1'b0;
    chk("b2b_done1_cycle", 0, 32'(d1), 32'd17);
    chk("b2b_done2_cycle", 0, 32'(d2), 32'd34);
    $display("scan inst0 settle=0 back-to-back done_cycles=%0d,%0d data=%02h", d1, d2, data_v[0]);

    // Reset in the middle of a scan, then start together with reset.
    inp_v[0]   = 8'h33;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (c = 1; c < 9; c++) tick();
    chk("mid_s_before_rst", 0, 32'(s_v[0]), 32'd4);
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    chk("rst_s", 0, 32'(s_v[0]), 32'd0);
    chk("rst_busy", 0, 32'(busy_v[0]), 32'd0);
    chk("rst_data", 0, 32'(data_v[0]), 32'd0);
    chk("rst_done", 0, 32'(done_v[0]), 32'd0);
    rst_v[0]   = 1'b1;
    start_v[0] = 1'b1;
    tick();
    rst_v[0]   = 1'b0;
    start_v[0] = 1'b0;
    tick();
    chk("rst_start_ignored", 0, 32'(busy_v[0]), 32'd0);
    scan(0, 8'h33, 17, 8'h33, 0, 0);

    // Every input pattern at SETTLE=0.
    for (int p = 0; p < 256; p++) scan(0, 8'(p), 17, 8'(p), 0, 0);

    // Random starts, input changes and occasional resets on all instances.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        rst_v[i]   = ($urandom_range(0, 299) == 0);
        start_v[i] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 7) == 0) inp_v[i] = 8'($urandom);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      rst_v[i]   = 1'b0;
      start_v[i] = 1'b0;
    end
    repeat (60) tick();
    for (int i = 0; i < 3; i++) chk("final_idle_busy", i, 32'(busy_v[i]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
